// File: rtl/wave_sdram_arbiter.sv
// SDRAM port arbiter: download writes take absolute priority, channel sample reads
// are served round-robin, and every access is bounded by a completion watchdog.
module wave_sdram_arbiter #(
    parameter int NCH     = 4,
    parameter int TIMEOUT = 63
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              dl_active,
    input  logic              dl_wr,
    input  logic [24:0]       dl_addr,
    input  logic [7:0]        dl_data,
    output logic              dl_wait,
    input  logic [NCH-1:0]    ch_req,
    input  logic [NCH*20-1:0] ch_addr,
    output logic [NCH-1:0]    ch_ack,
    output logic [15:0]       ch_data,
    output logic [24:0]       sd_addr,
    output logic              sd_we,
    output logic              sd_rd,
    output logic [7:0]        sd_din,
    input  logic [15:0]       sd_dout,
    input  logic              sd_done,
    output logic              timeout_err,
    output logic              overrun_err
);
    localparam int              GW       = $clog2(NCH);
    localparam logic [5:0]      TO_LIMIT = 6'(TIMEOUT);
    localparam logic [GW-1:0]   LAST_RST = GW'(NCH - 1);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;

    state_t          state_q, state_d;
    logic            hold_full_q, hold_full_d;
    logic [24:0]     hold_addr_q, hold_addr_d;
    logic [7:0]      hold_data_q, hold_data_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_grant_q, last_grant_d;
    logic [5:0]      cnt_q, cnt_d;
    logic            sd_we_q, sd_we_d;
    logic            sd_rd_q, sd_rd_d;
    logic [24:0]     sd_addr_q, sd_addr_d;
    logic [7:0]      sd_din_q, sd_din_d;
    logic [NCH-1:0]  ch_ack_q, ch_ack_d;
    logic [15:0]     ch_data_q, ch_data_d;
    logic            timeout_err_q, timeout_err_d;
    logic            overrun_err_q, overrun_err_d;

    logic [19:0]     ch_addr_arr [NCH];
    logic [GW-1:0]   rr_grant;
    logic            rr_found;
    int              rr_idx;

    for (genvar g = 0; g < NCH; g++) begin : g_addr
        assign ch_addr_arr[g] = ch_addr[g*20 +: 20];
    end

    // First requester above the last served channel, wrapping around.
    always_comb begin
        rr_grant = last_grant_q;
        rr_found = 1'b0;
        rr_idx   = 0;
        for (int i = 1; i <= NCH; i++) begin
            rr_idx = int'(last_grant_q) + i;
            if (rr_idx >= NCH) rr_idx = rr_idx - NCH;
            if (!rr_found && ch_req[GW'(rr_idx)]) begin
                rr_found = 1'b1;
                rr_grant = GW'(rr_idx);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        hold_full_d   = hold_full_q;
        hold_addr_d   = hold_addr_q;
        hold_data_d   = hold_data_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        cnt_d         = cnt_q;
        sd_we_d       = 1'b0;
        sd_rd_d       = 1'b0;
        sd_addr_d     = sd_addr_q;
        sd_din_d      = sd_din_q;
        ch_ack_d      = '0;
        ch_data_d     = ch_data_q;
        timeout_err_d = timeout_err_q;
        overrun_err_d = overrun_err_q;

        if (dl_wr) begin
            if (hold_full_q) begin
                overrun_err_d = 1'b1;
            end else begin
                hold_full_d = 1'b1;
                hold_addr_d = dl_addr;
                hold_data_d = dl_data;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (hold_full_q) begin
                    sd_we_d     = 1'b1;
                    sd_addr_d   = hold_addr_q;
                    sd_din_d    = hold_data_q;
                    hold_full_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = S_WRITE;
                end else if (!dl_active && rr_found) begin
                    sd_rd_d   = 1'b1;
                    sd_addr_d = {5'b0, ch_addr_arr[rr_grant]};
                    grant_d   = rr_grant;
                    cnt_d     = '0;
                    state_d   = S_READ;
                end
            end
            S_WRITE: begin
                if (sd_done) begin
                    state_d = S_IDLE;
                end else if (cnt_q == TO_LIMIT) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_READ: begin
                // A timed-out read still acks with zero data so the requester never stalls.
                if (sd_done) begin
                    ch_data_d         = sd_dout;
                    ch_ack_d[grant_q] = 1'b1;
                    last_grant_d      = grant_q;
                    state_d           = S_IDLE;
                end else if (cnt_q == TO_LIMIT) begin
                    ch_data_d         = 16'h0000;
                    ch_ack_d[grant_q] = 1'b1;
                    timeout_err_d     = 1'b1;
                    state_d           = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            hold_full_q   <= 1'b0;
            hold_addr_q   <= '0;
            hold_data_q   <= '0;
            grant_q       <= '0;
            last_grant_q  <= LAST_RST;
            cnt_q         <= '0;
            sd_we_q       <= 1'b0;
            sd_rd_q       <= 1'b0;
            sd_addr_q     <= '0;
            sd_din_q      <= '0;
            ch_ack_q      <= '0;
            ch_data_q     <= '0;
            timeout_err_q <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_full_q   <= hold_full_d;
            hold_addr_q   <= hold_addr_d;
            hold_data_q   <= hold_data_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            cnt_q         <= cnt_d;
            sd_we_q       <= sd_we_d;
            sd_rd_q       <= sd_rd_d;
            sd_addr_q     <= sd_addr_d;
            sd_din_q      <= sd_din_d;
            ch_ack_q      <= ch_ack_d;
            ch_data_q     <= ch_data_d;
            timeout_err_q <= timeout_err_d;
            overrun_err_q <= overrun_err_d;
        end
    end

    assign dl_wait     = hold_full_q;
    assign sd_we       = sd_we_q;
    assign sd_rd       = sd_rd_q;
    assign sd_addr     = sd_addr_q;
    assign sd_din      = sd_din_q;
    assign ch_ack      = ch_ack_q;
    assign ch_data     = ch_data_q;
    assign timeout_err = timeout_err_q;
    assign overrun_err = overrun_err_q;

endmodule

// File: tb/tb_wave_sdram_arbiter.sv
// Bench for wave_sdram_arbiter: SDRAM controller responder, bus monitor and a
// round-robin reference model driven by randomized request patterns.
module tb_wave_sdram_arbiter;
    localparam int NCH     = 4;
    localparam int TIMEOUT = 63;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              dl_active, dl_wr;
    logic [24:0]       dl_addr;
    logic [7:0]        dl_data;
    logic              dl_wait;
    logic [NCH-1:0]    ch_req, ch_ack;
    logic [NCH*20-1:0] ch_addr;
    logic [19:0]       addr_tb [NCH];
    logic [15:0]       ch_data, sd_dout;
    logic [24:0]       sd_addr;
    logic              sd_we, sd_rd, sd_done, resp_done, stray_done;
    logic [7:0]        sd_din;
    logic              timeout_err, overrun_err;

    int n_tests, n_fail, cyc, resp_lat;
    bit resp_hold;

    typedef struct { logic [24:0] addr; logic [7:0] din; int c; } cmd_t;
    typedef struct { logic [NCH-1:0] v; logic [15:0] d; int c; } ack_t;
    cmd_t        wr_q[$], rd_q[$];
    ack_t        ack_q[$];
    logic [15:0] dout_q[$];

    always #5 clk = ~clk;
    assign sd_done = resp_done | stray_done;
    for (genvar g = 0; g < NCH; g++) begin : g_pack
        assign ch_addr[g*20 +: 20] = addr_tb[g];
    end

    wave_sdram_arbiter #(.NCH(NCH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n), .dl_active(dl_active), .dl_wr(dl_wr),
        .dl_addr(dl_addr), .dl_data(dl_data), .dl_wait(dl_wait), .ch_req(ch_req),
        .ch_addr(ch_addr), .ch_ack(ch_ack), .ch_data(ch_data), .sd_addr(sd_addr),
        .sd_we(sd_we), .sd_rd(sd_rd), .sd_din(sd_din), .sd_dout(sd_dout),
        .sd_done(sd_done), .timeout_err(timeout_err), .overrun_err(overrun_err)
    );

    // Bus monitor: records every command and ack with its cycle number.
    initial begin
        cmd_t cm;
        ack_t ak;
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (sd_we) begin cm.addr = sd_addr; cm.din = sd_din; cm.c = cyc; wr_q.push_back(cm); end
            if (sd_rd) begin cm.addr = sd_addr; cm.din = 8'h00; cm.c = cyc; rd_q.push_back(cm); end
            if (ch_ack != '0) begin ak.v = ch_ack; ak.d = ch_data; ak.c = cyc; ack_q.push_back(ak); end
        end
    end

    // Controller model: sd_done sampled resp_lat edges after the command edge.
    initial begin
        bit is_rd;
        resp_done = 1'b0;
        sd_dout   = '0;
        forever begin
            @(posedge clk);
            #1;
            if ((sd_rd || sd_we) && !resp_hold) begin
                is_rd = sd_rd;
                repeat (resp_lat) @(posedge clk);
                #1;
                resp_done = 1'b1;
                sd_dout   = 16'($urandom);
                if (is_rd) dout_q.push_back(sd_dout);
                @(posedge clk);
                #1;
                resp_done = 1'b0;
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "global timeout");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_q();
        wr_q.delete(); rd_q.delete(); ack_q.delete(); dout_q.delete();
    endtask

    task automatic do_reset();
        reset_n = 1'b0; dl_active = 1'b0; dl_wr = 1'b0; ch_req = '0;
        stray_done = 1'b0; resp_hold = 1'b0;
        repeat (3) tick();
        clear_q();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic wait_ack(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (ack_q.size() > 0) begin ok = 1'b1; break; end
            tick();
        end
        if (!ok) begin
            n_tests++; n_fail++;
            $display("FAIL ack_wait: no ch_ack within %0d cycles (cycle %0d)", budget, cyc);
        end
    endtask

    function automatic int onehot_idx(input logic [NCH-1:0] v);
        logic [NCH-1:0] sh;
        int idx = -1;
        if ($countones(v) != 1) return -1;
        for (int k = 0; k < NCH; k++) begin sh = v >> k; if (sh[0]) idx = k; end
        return idx;
    endfunction

    // Reference rule: first set bit searching upward from last+1 with wrap.
    function automatic int rr_next(input logic [NCH-1:0] m, input int last);
        logic [NCH-1:0] sh;
        for (int i = 1; i <= NCH; i++) begin
            sh = m >> ((last + i) % NCH);
            if (sh[0]) return (last + i) % NCH;
        end
        return -1;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0; dl_active = 1'b0; dl_wr = 1'b0; ch_req = '0;
        dl_addr = '0; dl_data = '0; stray_done = 1'b0; resp_hold = 1'b0; resp_lat = 3;
        for (int k = 0; k < NCH; k++) addr_tb[k] = 20'($urandom);
        repeat (3) tick();
        n_tests++;
        if ({dl_wait, sd_we, sd_rd, ch_ack, timeout_err, overrun_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 0", {dl_wait, sd_we, sd_rd, ch_ack, timeout_err, overrun_err});
        end
        n_tests++;
        if ({sd_addr, sd_din, ch_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: addr %h din %h data %h want 0", sd_addr, sd_din, ch_data);
        end
        clear_q();
        reset_n = 1'b1;
        repeat (4) tick();
        n_tests++;
        if (rd_q.size() + wr_q.size() + ack_q.size() !== 0) begin
            n_fail++;
            $display("FAIL reset_quiet: %0d bus events with no requests, want 0", rd_q.size() + wr_q.size() + ack_q.size());
        end
    endtask

    task automatic test_dl_write();
        int cd;
        clear_q();
        resp_lat = 3;
        dl_addr = 25'h0000010; dl_data = 8'hA5; dl_wr = 1'b1;
        tick();
        dl_wr = 1'b0;
        n_tests++;
        if (dl_wait !== 1'b1 || sd_we !== 1'b0) begin
            n_fail++; $display("FAIL dl_wait_set: dl_wait %b sd_we %b want 1 0", dl_wait, sd_we);
        end
        tick();
        n_tests++;
        if (sd_we !== 1'b1) begin n_fail++; $display("FAIL dl_we: sd_we %b want 1", sd_we); end
        n_tests++;
        if (sd_addr !== 25'h0000010 || sd_din !== 8'hA5) begin
            n_fail++; $display("FAIL dl_we_data: addr %h din %h want 0000010 a5", sd_addr, sd_din);
        end
        n_tests++;
        if (dl_wait !== 1'b0) begin n_fail++; $display("FAIL dl_wait_clr: dl_wait %b want 0", dl_wait); end
        repeat (6) tick();
        n_tests++;
        if (dl_wait !== 1'b0 || timeout_err !== 1'b0 || wr_q.size() !== 1) begin
            n_fail++;
            $display("FAIL dl_after_done: dl_wait %b terr %b writes %0d want 0 0 1", dl_wait, timeout_err, wr_q.size());
        end
        for (int n = 0; n < 4; n++) begin
            clear_q();
            resp_lat = $urandom_range(1, 5);
            dl_addr = 25'($urandom); dl_data = 8'($urandom); dl_wr = 1'b1;
            cd = cyc;
            tick();
            dl_wr = 1'b0;
            for (int i = 0; i < 5 && wr_q.size() == 0; i++) tick();
            n_tests++;
            if (wr_q.size() == 0) begin
                n_fail++; $display("FAIL dl_rand_%0d: no sd_we, want one", n);
            end else if (wr_q[0].addr !== dl_addr || wr_q[0].din !== dl_data || wr_q[0].c - cd !== 2) begin
                n_fail++;
                $display("FAIL dl_rand_%0d: addr %h din %h lat %0d want %h %h 2", n, wr_q[0].addr,
                         wr_q[0].din, wr_q[0].c - cd, dl_addr, dl_data);
            end
            repeat (resp_lat + 3) tick();
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        int last, prev, ch, exp;
        ack_t a;
        do_reset();
        resp_lat = 4;
        for (int k = 0; k < NCH; k++) addr_tb[k] = 20'($urandom);
        ch_req = 4'b1101;
        prev = cyc;
        last = NCH - 1;
        for (int n = 0; n < 5; n++) begin
            wait_ack(40, ok);
            if (!ok) break;
            a = ack_q.pop_front();
            ch = onehot_idx(a.v);
            exp = rr_next(4'b1101, last);
            if (n == 4) ch_req = '0;
            n_tests++;
            if (ch !== exp) begin n_fail++; $display("FAIL rr_grant_%0d: ch %0d want %0d", n, ch, exp); end
            n_tests++;
            if (a.c - prev !== 6) begin n_fail++; $display("FAIL rr_latency_%0d: %0d cycles want 6", n, a.c - prev); end
            n_tests++;
            if (dout_q.size() == 0 || rd_q.size() == 0) begin
                n_fail++; $display("FAIL rr_data_%0d: missing read/response", n);
            end else begin
                if (a.d !== dout_q[0] || rd_q[0].addr !== {5'b0, addr_tb[exp]}) begin
                    n_fail++;
                    $display("FAIL rr_data_%0d: data %h addr %h want %h %h", n, a.d, rd_q[0].addr, dout_q[0], {5'b0, addr_tb[exp]});
                end
                void'(dout_q.pop_front());
                void'(rd_q.pop_front());
            end
            last = exp;
            prev = a.c;
        end
        ch_req = '0;
        repeat (10) tick();
        n_tests++;
        if (rd_q.size() !== 0) begin n_fail++; $display("FAIL rr_drain: %0d extra reads want 0", rd_q.size()); end
    endtask

    task automatic test_random_rr();
        bit ok;
        int last, ch, exp;
        logic [NCH-1:0] mask, add, rose, sh;
        ack_t a;
        do_reset();
        last = NCH - 1;
        mask = '0;
        for (int n = 0; n < 30; n++) begin
            if (mask == '0) begin
                mask = NCH'($urandom_range(1, 15));
                for (int k = 0; k < NCH; k++) addr_tb[k] = 20'($urandom);
                resp_lat = $urandom_range(1, 5);
                ch_req = mask;
            end
            wait_ack(100, ok);
            if (!ok) break;
            a = ack_q.pop_front();
            ch = onehot_idx(a.v);
            exp = rr_next(mask, last);
            n_tests++;
            if (ch !== exp) begin n_fail++; $display("FAIL rand_grant_%0d: ch %0d want %0d mask %b", n, ch, exp, mask); end
            n_tests++;
            if (dout_q.size() == 0 || rd_q.size() == 0 || exp < 0) begin
                n_fail++; $display("FAIL rand_data_%0d: missing read/response", n);
            end else begin
                if (a.d !== dout_q[0] || rd_q[0].addr !== {5'b0, addr_tb[exp]}) begin
                    n_fail++;
                    $display("FAIL rand_data_%0d: data %h addr %h want %h %h", n, a.d, rd_q[0].addr, dout_q[0], {5'b0, addr_tb[exp]});
                end
                void'(dout_q.pop_front());
                void'(rd_q.pop_front());
            end
            if (exp >= 0) last = exp;
            if ($urandom_range(0, 2) != 0 && ch >= 0) mask = mask & ~(NCH'(1) << ch);
            add = ($urandom_range(0, 2) == 0) ? NCH'($urandom) : '0;
            rose = add & ~mask;
            for (int k = 0; k < NCH; k++) begin sh = rose >> k; if (sh[0]) addr_tb[k] = 20'($urandom); end
            mask = mask | add;
            if (n == 29) mask = '0;
            resp_lat = $urandom_range(1, 5);
            ch_req = mask;
        end
        ch_req = '0;
        repeat (12) tick();
        n_tests++;
        if (rd_q.size() + ack_q.size() !== 0) begin
            n_fail++; $display("FAIL rand_drain: %0d stray events want 0", rd_q.size() + ack_q.size());
        end
    endtask

    task automatic test_dl_priority();
        bit ok, got;
        logic [24:0] ea [3];
        logic [7:0]  ed [3];
        ack_t a;
        clear_q();
        resp_lat = 2;
        dl_active = 1'b1;
        addr_tb[1] = 20'($urandom);
        ch_req = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            ea[k] = 25'($urandom); ed[k] = 8'($urandom);
            dl_addr = ea[k]; dl_data = ed[k]; dl_wr = 1'b1;
            tick();
            dl_wr = 1'b0;
            repeat (7) tick();
        end
        n_tests++;
        if (wr_q.size() !== 3 || rd_q.size() !== 0) begin
            n_fail++; $display("FAIL prio_counts: writes %0d reads %0d want 3 0", wr_q.size(), rd_q.size());
        end
        for (int k = 0; k < 3 && k < wr_q.size(); k++) begin
            n_tests++;
            if (wr_q[k].addr !== ea[k] || wr_q[k].din !== ed[k]) begin
                n_fail++; $display("FAIL prio_wr_%0d: %h %h want %h %h", k, wr_q[k].addr, wr_q[k].din, ea[k], ed[k]);
            end
        end
        dl_active = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (sd_rd) begin got = 1'b1; break; end
        end
        n_tests++;
        if (!got || sd_addr !== {5'b0, addr_tb[1]}) begin
            n_fail++; $display("FAIL prio_read_after: sd_rd seen %b addr %h want 1 %h", got, sd_addr, {5'b0, addr_tb[1]});
        end
        wait_ack(20, ok);
        if (ok) begin
            a = ack_q.pop_front();
            ch_req = '0;
            n_tests++;
            if (a.v !== 4'b0010 || dout_q.size() == 0 || a.d !== dout_q[0]) begin
                n_fail++; $display("FAIL prio_ack: ack %b data %h want 0010 and responder data", a.v, a.d);
            end
        end
        ch_req = '0;
        repeat (5) tick();
    endtask

    task automatic test_overrun();
        do_reset();
        resp_lat = 3;
        n_tests++;
        if (overrun_err !== 1'b0) begin n_fail++; $display("FAIL ovr_init: %b want 0", overrun_err); end
        dl_addr = 25'h0123456; dl_data = 8'h11; dl_wr = 1'b1;
        tick();
        dl_addr = 25'h0654321; dl_data = 8'h22;
        tick();
        dl_wr = 1'b0;
        n_tests++;
        if (overrun_err !== 1'b1) begin n_fail++; $display("FAIL ovr_set: %b want 1", overrun_err); end
        repeat (8) tick();
        n_tests++;
        if (wr_q.size() !== 1 || wr_q[0].addr !== 25'h0123456 || wr_q[0].din !== 8'h11) begin
            n_fail++; $display("FAIL ovr_dropped: %0d writes want 1 of 0123456/11", wr_q.size());
        end
        dl_addr = 25'h0000333; dl_data = 8'h33; dl_wr = 1'b1;
        tick();
        dl_wr = 1'b0;
        repeat (8) tick();
        n_tests++;
        if (wr_q.size() !== 2 || wr_q[1].din !== 8'h33 || overrun_err !== 1'b1) begin
            n_fail++; $display("FAIL ovr_sticky: writes %0d overrun %b want 2 1", wr_q.size(), overrun_err);
        end
        do_reset();
        n_tests++;
        if (overrun_err !== 1'b0) begin n_fail++; $display("FAIL ovr_reset: %b want 0", overrun_err); end
    endtask

    task automatic test_timeout();
        bit ok;
        int ci, ch;
        ack_t a;
        do_reset();
        resp_hold = 1'b1;
        addr_tb[3] = 20'($urandom);
        ch_req = 4'b1000;
        for (int i = 0; i < 5 && rd_q.size() == 0; i++) tick();
        ci = (rd_q.size() > 0) ? rd_q[0].c : cyc;
        repeat (20) tick();
        n_tests++;
        if (timeout_err !== 1'b0 || ack_q.size() !== 0) begin
            n_fail++; $display("FAIL to_early: terr %b acks %0d want 0 0", timeout_err, ack_q.size());
        end
        wait_ack(100, ok);
        if (ok) begin
            a = ack_q.pop_front();
            ch_req = '0;
            ch = onehot_idx(a.v);
            n_tests++;
            if (ch !== 3 || a.d !== 16'h0000) begin
                n_fail++; $display("FAIL to_ack: ch %0d data %h want 3 0000", ch, a.d);
            end
            n_tests++;
            if (a.c - ci !== 64) begin n_fail++; $display("FAIL to_latency: %0d want 64", a.c - ci); end
            n_tests++;
            if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_err: %b want 1", timeout_err); end
        end
        ch_req = '0;
        resp_hold = 1'b0;
        resp_lat = 2;
        tick();
        clear_q();
        addr_tb[1] = 20'($urandom);
        ch_req = 4'b0010;
        wait_ack(30, ok);
        if (ok) begin
            a = ack_q.pop_front();
            ch_req = '0;
            n_tests++;
            if (a.v !== 4'b0010 || dout_q.size() == 0 || a.d !== dout_q[0] || timeout_err !== 1'b1) begin
                n_fail++; $display("FAIL to_recover: ack %b data %h terr %b want 0010 responder-data 1", a.v, a.d, timeout_err);
            end
        end
        ch_req = '0;
        repeat (4) tick();
    endtask

    task automatic test_midreset();
        bit ok;
        int ch;
        ack_t a;
        do_reset();
        resp_lat = 2;
        addr_tb[1] = 20'($urandom);
        ch_req = 4'b0010;
        wait_ack(30, ok);
        ch_req = '0;
        repeat (3) tick();
        resp_hold = 1'b1;
        addr_tb[2] = 20'($urandom) | 20'h1;
        ch_req = 4'b0100;
        repeat (6) tick();
        reset_n = 1'b0;
        ch_req = '0;
        #1;
        n_tests++;
        if ({dl_wait, sd_we, sd_rd, ch_ack, timeout_err, overrun_err, sd_addr, sd_din, ch_data} !== '0) begin
            n_fail++; $display("FAIL mid_async: addr %h data %h ack %b want all zero", sd_addr, ch_data, ch_ack);
        end
        repeat (2) tick();
        reset_n = 1'b1;
        clear_q();
        tick();
        stray_done = 1'b1;
        tick();
        stray_done = 1'b0;
        repeat (4) tick();
        n_tests++;
        if (ack_q.size() + rd_q.size() + wr_q.size() !== 0 || ch_data !== 16'h0000) begin
            n_fail++; $display("FAIL mid_stray: %0d events data %h want none 0000", ack_q.size() + rd_q.size() + wr_q.size(), ch_data);
        end
        resp_hold = 1'b0;
        addr_tb[0] = 20'($urandom);
        ch_req = 4'b0101;
        wait_ack(30, ok);
        if (ok) begin
            a = ack_q.pop_front();
            ch_req = '0;
            ch = onehot_idx(a.v);
            n_tests++;
            if (ch !== rr_next(4'b0101, NCH - 1)) begin
                n_fail++; $display("FAIL mid_tie: ch %0d want %0d", ch, rr_next(4'b0101, NCH - 1));
            end
        end
        ch_req = '0;
        repeat (4) tick();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_dl_write();
        test_round_robin();
        test_random_rr();
        test_dl_priority();
        test_overrun();
        test_timeout();
        test_midreset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
